// File: rtl/dmi_initiator.sv
// rtl/dmi_initiator.sv - DMI initiator: scan word to dmi_req_t/dmi_resp_t, sticky dmistat; watchdog under DMI_TIMEOUT_EN
module dmi_initiator #(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        update_i,
  input  logic        capture_i,
  input  logic [40:0] dmi_wr_i,
  output logic [40:0] dmi_rd_o,
  input  logic        dmireset_i,
  input  logic        dmihardreset_i,
  output logic        dmi_req_valid_o,
  input  logic        dmi_req_ready_i,
  output logic [40:0] dmi_req_o,
  input  logic        dmi_resp_valid_i,
  output logic        dmi_resp_ready_o,
  input  logic [33:0] dmi_resp_i,
  output logic [1:0]  dmistat_o,
  output logic        busy_o
);

  localparam logic [1:0] DTM_READ    = 2'd1;
  localparam logic [1:0] DTM_WRITE   = 2'd2;
  localparam logic [1:0] DTM_SUCCESS = 2'd0;
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_FAILED  = 2'd2;
  localparam logic [1:0] ERR_BUSY    = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e      state_q, state_d;
  logic [40:0] req_q, req_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  error_q, error_d;
  logic [1:0]  upd_op;
  logic [1:0]  status;
  logic        timeout;

  assign upd_op = dmi_wr_i[33:32];

`ifdef DMI_TIMEOUT_EN
  logic [15:0] cnt_q;

  assign timeout = (state_q != IDLE) && (cnt_q == 16'(TimeoutCycles - 1));

  // Watchdog: counts cycles spent in the current REQ/WAIT visit, restarts on every state change
  always_ff @(posedge clk_i) begin
    if (rst_i || (state_d != state_q) || (state_q == IDLE)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TimeoutCycles);
  assign timeout = 1'b0;
`endif

  assign busy_o     = (state_q != IDLE);
  assign status     = (error_q != ERR_NONE) ? error_q : (busy_o ? ERR_BUSY : ERR_NONE);
  assign dmi_rd_o   = {req_q[40:34], data_q, status};
  assign dmi_req_o  = req_q;
  assign dmistat_o  = error_q;

  // Next-state, transaction registers, sticky error and handshake outputs
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    data_d           = data_q;
    error_d          = dmireset_i ? ERR_NONE : error_q;
    dmi_req_valid_o  = 1'b0;
    dmi_resp_ready_o = 1'b0;

    // A scan touching the register mid-transaction is reported as busy; a failure below overrides it
    if (busy_o && (error_d == ERR_NONE) && (update_i || capture_i)) begin
      error_d = ERR_BUSY;
    end

    unique case (state_q)
      IDLE: begin
        if (update_i && (error_d == ERR_NONE) && ((upd_op == DTM_READ) || (upd_op == DTM_WRITE))) begin
          req_d   = dmi_wr_i;
          state_d = REQ;
        end
      end
      REQ: begin
        dmi_req_valid_o = 1'b1;
        if (dmi_req_ready_i) begin
          state_d = WAIT;
        end else if (timeout) begin
          state_d = IDLE;
          error_d = ERR_FAILED;
        end
      end
      WAIT: begin
        dmi_resp_ready_o = 1'b1;
        if (dmi_resp_valid_i) begin
          state_d = IDLE;
          data_d  = (req_q[33:32] == DTM_READ) ? dmi_resp_i[33:2] : req_q[31:0];
          if (dmi_resp_i[1:0] != DTM_SUCCESS) begin
            error_d = ERR_FAILED;
          end
        end else if (timeout) begin
          state_d = IDLE;
          error_d = ERR_FAILED;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hard reset abandons whatever is in flight and wins over every other input
    if (dmihardreset_i) begin
      state_d = IDLE;
      req_d   = req_q;
      data_d  = data_q;
      error_d = ERR_NONE;
    end
  end

  // State and data registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      data_q  <= '0;
      error_q <= ERR_NONE;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      error_q <= error_d;
    end
  end

endmodule
